fifo_flex: RTL and testbench

Parametrised synchronous show-ahead FIFO; next-generation replacement for the basic valid/ready FIFO in the ALU/FIFO datapath. Adds non-power-of-two depth, an occupancy count wide enough to represent full, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Sits between producer and consumer stages on a single clock domain.

---
 rtl/fifo_flex_pkg.sv | 17 +
 rtl/fifo_flex_mem.sv | 29 ++
 rtl/fifo_flex.sv | 141 ++++++++++++++
 tb/tb_fifo_flex.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// Shared sizing helpers for the flexible-depth show-ahead FIFO.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
//
// fifo_cnt_w(depth) : bits needed to hold an occupancy of 0..depth
// fifo_ptr_w(depth) : bits needed to address depth entries (at least 1)
package fifo_flex_pkg;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// Storage array for fifo_flex: DEPTH x DATA_WIDTH registers, no reset.
// Latency: write lands on the clock edge; read port is combinational.
// Backpressure: none; the caller only asserts we for accepted writes.
//
// Ports: clk_i, we, waddr, wdata (write port); raddr -> rdata (async read).
module fifo_flex_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Show-ahead single-clock FIFO with any depth >= 2, level flags, flush and sticky errors.
// Latency: 1 cycle write-to-read; flags follow the registered count one cycle after a handshake.
// Backpressure: data_in_ready drops when full or flushing; no bypass or pass-through paths.
//
// Ports: clk_i, arst (async, active-high), flush_i (sync clear of pointers/count/errors),
//   data_in/_valid/_ready (producer), data_out/_valid/_ready (consumer),
//   count_o, almost_full_o, almost_empty_o, overflow_o, underflow_o, max_level_o.
// Optional macro FIFO_FLEX_WATERMARK_EN: when defined, max_level_o tracks peak occupancy;
//   otherwise max_level_o is tied to zero.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_TH      = DEPTH - 1,
    parameter int AE_TH      = 1
) (
    input  logic                          clk_i,
    input  logic                          arst,
    input  logic                          flush_i,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic                          overflow_o,
    output logic                          underflow_o,
    output logic [fifo_cnt_w(DEPTH)-1:0]  max_level_o
);

    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t FULL_C   = cnt_t'(DEPTH);
    localparam cnt_t AF_C     = cnt_t'(AF_TH);
    localparam cnt_t AE_C     = cnt_t'(AE_TH);
    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);

    cnt_t count, count_next;
    ptr_t wr_ptr, rd_ptr;
    logic wr_en, rd_en;
    logic is_full, is_empty;

    // Explicit wrap so non-power-of-two depths never address past the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

    assign is_full        = (count == FULL_C);
    assign is_empty       = (count == '0);
    assign data_in_ready  = !is_full && !flush_i;
    assign data_out_valid = !is_empty && !flush_i;
    assign wr_en          = data_in_valid && data_in_ready;
    assign rd_en          = data_out_valid && data_out_ready;

    always_comb begin
        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else if (wr_en && !rd_en) begin
            count_next = count + cnt_t'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst) begin
        if (arst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            count <= count_next;
            if (flush_i) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (rd_en) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                // Errors stay latched until reset or flush.
                if (data_in_valid && is_full) begin
                    overflow_o <= 1'b1;
                end
                if (data_out_ready && is_empty) begin
                    underflow_o <= 1'b1;
                end
            end
        end
    end

    fifo_flex_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    assign count_o        = count;
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);

`ifdef FIFO_FLEX_WATERMARK_EN
    cnt_t max_level;

    always_ff @(posedge clk_i or posedge arst) begin
        if (arst) begin
            max_level <= '0;
        end else if (flush_i) begin
            max_level <= '0;
        end else if (count_next > max_level) begin
            max_level <= count_next;
        end
    end

    assign max_level_o = max_level;
`else
    assign max_level_o = '0;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex at DEPTH=5, AF_TH=4, AE_TH=1.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Peak-level expectations depend on whether FIFO_FLEX_WATERMARK_EN is defined.
module tb_fifo_flex;

    localparam int DW = 8;
    localparam int DEPTH = 5;
`ifdef FIFO_FLEX_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          arst = 1'b1;
    logic          flush_i = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic [2:0]    count_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          overflow_o;
    logic          underflow_o;
    logic [2:0]    max_level_o;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    fifo_flex #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_TH      (4),
        .AE_TH      (1)
    ) dut (
        .clk_i          (clk_i),
        .arst           (arst),
        .flush_i        (flush_i),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .count_o        (count_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .max_level_o    (max_level_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        data_in = d;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
        data_out_ready = 1'b1;
        chk({tag, "_vld"}, 32'(data_out_valid), 32'd1);
        chk(tag, 32'(data_out), 32'(exp));
        step();
        data_out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_in_rdy"}, 32'(data_in_ready), 32'd1);
        chk({tag, "_out_vld"}, 32'(data_out_valid), 32'd0);
        chk({tag, "_af"}, 32'(almost_full_o), 32'd0);
        chk({tag, "_ae"}, 32'(almost_empty_o), 32'd1);
        chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
        chk({tag, "_udf"}, 32'(underflow_o), 32'd0);
        chk({tag, "_max"}, 32'(max_level_o), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outputs("rst");
        arst = 1'b0;
        step();

        // Fill to full: count, almost flags and ready follow the registered count.
        for (int i = 0; i < DEPTH; i++) begin
            data_in = 8'(8'h11 + i);
            data_in_valid = 1'b1;
            step();
            chk("fill_count", 32'(count_o), 32'(i + 1));
            chk("fill_af", 32'(almost_full_o), 32'((i + 1) >= 4));
            chk("fill_ae", 32'(almost_empty_o), 32'((i + 1) <= 1));
        end
        data_in_valid = 1'b0;
        chk("full_in_rdy", 32'(data_in_ready), 32'd0);
        chk("full_ovf", 32'(overflow_o), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            pop_chk("drain_dat", 8'(8'h11 + i));
            chk("drain_count", 32'(count_o), 32'(DEPTH - 1 - i));
        end
        chk("drained_vld", 32'(data_out_valid), 32'd0);
        chk("drained_udf", 32'(underflow_o), 32'd0);
        chk("peak_after_fill", 32'(max_level_o), WM ? 32'd5 : 32'd0);

        // Pointer wrap: 3 in/out moves both pointers to 3, then 5 in/out crosses 4->0.
        for (int i = 0; i < 3; i++) push(8'(8'h21 + i));
        for (int i = 0; i < 3; i++) pop_chk("wrap3_dat", 8'(8'h21 + i));
        for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
        chk("wrap_full_count", 32'(count_o), 32'd5);
        for (int i = 0; i < 5; i++) pop_chk("wrap5_dat", 8'(8'h31 + i));
        chk("wrap_empty_count", 32'(count_o), 32'd0);

        // Steady state: one write and one read per cycle holds count at 3.
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        data_in_valid = 1'b1;
        data_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'(8'h43 + k);
            chk("stream_dat", 32'(data_out), 32'(8'h40 + k));
            step();
            chk("stream_count", 32'(count_o), 32'd3);
        end
        data_in_valid = 1'b0;
        data_out_ready = 1'b0;
        push(8'h57);
        push(8'h58);
        chk("refill_count", 32'(count_o), 32'd5);

        // Full with read and a valid write: only the read is accepted.
        data_in = 8'h99;
        data_in_valid = 1'b1;
        data_out_ready = 1'b1;
        chk("fullrw_in_rdy", 32'(data_in_ready), 32'd0);
        chk("fullrw_dat", 32'(data_out), 32'h54);
        step();
        data_in_valid = 1'b0;
        data_out_ready = 1'b0;
        chk("fullrw_count", 32'(count_o), 32'd4);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) pop_chk("fullrw_drain", 8'(8'h55 + i));
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Read request while empty latches underflow.
        data_out_ready = 1'b1;
        step();
        data_out_ready = 1'b0;
        chk("udf_set", 32'(underflow_o), 32'd1);
        step();
        chk("udf_sticky", 32'(underflow_o), 32'd1);

        flush_i = 1'b1;
        #1;
        chk("flush_in_rdy", 32'(data_in_ready), 32'd0);
        step();
        flush_i = 1'b0;
        chk("flush_ovf", 32'(overflow_o), 32'd0);
        chk("flush_udf", 32'(underflow_o), 32'd0);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_vld", 32'(data_out_valid), 32'd0);
        chk("flush_max", 32'(max_level_o), 32'd0);

        // Flush at count 3 with both handshakes requested: neither is accepted.
        for (int i = 0; i < 3; i++) push(8'(8'h61 + i));
        flush_i = 1'b1;
        data_in = 8'h77;
        data_in_valid = 1'b1;
        data_out_ready = 1'b1;
        #1;
        chk("fl3_in_rdy", 32'(data_in_ready), 32'd0);
        chk("fl3_out_vld", 32'(data_out_valid), 32'd0);
        step();
        flush_i = 1'b0;
        data_in_valid = 1'b0;
        data_out_ready = 1'b0;
        chk("fl3_count", 32'(count_o), 32'd0);
        chk("fl3_vld", 32'(data_out_valid), 32'd0);
        push(8'hAA);
        chk("post_flush_count", 32'(count_o), 32'd1);
        pop_chk("post_flush_dat", 8'hAA);

        // Peak tracking: fill to 4, drain, peak holds; flush clears it.
        for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
        for (int i = 0; i < 4; i++) pop_chk("wm_drain", 8'(8'hB0 + i));
        chk("wm_peak", 32'(max_level_o), WM ? 32'd4 : 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("wm_flush", 32'(max_level_o), 32'd0);

        // Asynchronous reset mid-operation, asserted away from any clock edge.
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
        data_in_valid = 1'b1;
        data_in = 8'hC3;
        step();
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        chk("pre_rst_ovf", 32'(overflow_o), 32'd1);
        #2;
        arst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        step();
        arst = 1'b0;
        step();
        chk("after_rst_count", 32'(count_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
